lm_sm_sequencer: RTL and testbench
==================================

Name: lm_sm_sequencer

Overview:
Front-end controller that expands multiple-register load/store instructions (LM/SM) into one micro-instruction per set bit of the 8-bit register list.
- Sits beside the hazard unit at the fetch / IF-ID boundary.
- Holds the PC and steers the IF/ID instruction-load mux to the generated micro-instructions.
- Flags the first transfer so execute selects the base register rather than the incremented address.

Parameters:
LM_OPCODE, 4'b0110, opcode IR[15:12] of load-multiple
SM_OPCODE, 4'b0111, opcode IR[15:12] of store-multiple

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
if_id_ir  in  16  instruction currently held in IF/ID pipeline register
if_id_valid  in  1  IF/ID holds a live (non-flushed) instruction
stall_in  in  1  hazard-unit stall; IF/ID and PC frozen this cycle
flush_in  in  1  branch/jump flush of IF/ID from a later stage
ir_load_mux  out  1  1 = IF/ID loads new_ir_multi instead of fetched instruction
new_ir_multi  out  16  generated micro-instruction
first_multiple  out  1  qualifies IF/ID instruction as first transfer of an LM/SM
pc_write  out  1  PC update enable
busy  out  1  state == SEQ

Behaviour:
Interface
- Single clock clk; reset is synchronous, active-high.
- All registers update on posedge clk.

State
- Two-state FSM: IDLE, SEQ.
- rem[7:0]: remaining register list, not yet issued.
- hdr[6:0]: latched {opcode, regA} = IR[15:9].

Definitions
- trigger = IDLE & if_id_valid & (if_id_ir[15:12] == LM_OPCODE or SM_OPCODE) & !stall_in & !flush_in.
- src = trigger ? (if_id_ir[7:0] & ~lowbit(if_id_ir[7:0])) : rem
  - lowbit(x) = x & -x.
  - The transfer for the lowest set bit is the original instruction already in IF/ID.
- idx = index of the lowest set bit of src. Transfers are issued in ascending register order, R0 first.
- Micro-op format: new_ir_multi = {hdr_or_IR[15:9], idx[2:0], 6'b000000}.

Combinational outputs (Mealy)
- Default: ir_load_mux=0, pc_write=1, first_multiple=0, new_ir_multi=16'h0000.
- IDLE, trigger:
  - first_multiple=1.
  - If src != 0: ir_load_mux=1, pc_write=0, new_ir_multi = uop(idx).
  - If src == 0 (single register or empty list): defaults otherwise; no sequencing.
- SEQ, !stall_in, rem != 0: ir_load_mux=1, pc_write=0, new_ir_multi = uop(idx).
- SEQ, !stall_in, rem == 0: defaults (pc_write=1); exit cycle, fetch resumes.
- SEQ, stall_in: ir_load_mux=0, pc_write=0; state and rem held.
- IDLE, stall_in: pc_write passes through as 1; the hazard unit gates the PC itself.
- Any flush_in: defaults.

Next state
- reset: IDLE, rem=0, hdr=0.
- flush_in (priority over stall and everything else): IDLE, rem=0, regardless of state.
- IDLE & trigger & src != 0: SEQ, rem <= src & ~lowbit(src), hdr <= if_id_ir[15:9].
- SEQ & !stall_in & rem != 0: rem <= rem & ~lowbit(rem).
- SEQ & !stall_in & rem == 0: IDLE.

Latency
- List with k set bits, k >= 2: k unstalled cycles from trigger back to IDLE.
- pc_write is low for exactly k-1 of those cycles.
- k = 0 or 1: zero extra cycles.

Boundaries
- Empty list: behaves as a single instruction with first_multiple=1; decode treats it as a no-op.
- List 8'hFF: 8 transfers, R0..R7.
- Micro-ops entering IF/ID never retrigger, because state is SEQ while they are resident.
- Reset or flush mid-sequence abandons the remaining transfers.

Decomposition:
Shared package (lca_pkg):
- LM/SM opcode constants.
- seq_state_t enum {IDLE, SEQ}.
- Micro-op field positions.

Sub-module lowbit_encoder:
- 8-bit input; outputs 3-bit idx, valid, and the input with its lowest bit cleared.
- Instantiated once on src.

Test Plan:
1. LM, IR=16'h6C06 (regA=R6, list 8'h06) -> trigger cycle: first_multiple=1, new_ir_multi=16'h6C80 (R2), ir_load_mux=1, pc_write=0. Next cycle: SEQ exit, pc_write=1, busy=1. Then IDLE.
2. SM, list 8'hFF -> micro-ops carry idx 1..7 on 7 consecutive cycles; pc_write low 7 cycles; busy high 7 cycles.
3. LM, list 8'h10 and list 8'h00 -> first_multiple=1 one cycle; ir_load_mux=0, pc_write=1 throughout; busy never asserts.
4. SM list 8'h0B, stall_in high 2 cycles in SEQ -> outputs frozen (pc_write=0, ir_load_mux=0). Sequence resumes with idx=3; total 3 + 2 cycles.
5. LM list 8'hF0, flush_in on the 2nd SEQ cycle -> that cycle: defaults. Next cycle: IDLE, rem=0, busy=0.
6. reset asserted mid-sequence -> next cycle: IDLE, busy=0, pc_write=1, ir_load_mux=0. Also: non-LM/SM opcode or if_id_valid=0 never triggers.

Source files
------------

// File: rtl/lca_pkg.sv
// Shared definitions for the LM/SM front-end sequencer: opcodes, FSM states,
// micro-op field positions and a small bit helper.
package lca_pkg;

    localparam logic [3:0] LM_OP_C = 4'b0110;
    localparam logic [3:0] SM_OP_C = 4'b0111;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } seq_state_t;

    // Instruction / micro-op field positions
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int HDR_MSB  = 15;
    localparam int HDR_LSB  = 9;
    localparam int LIST_MSB = 7;
    localparam int UOP_IDX_LSB = 6;

    // x & ~lowbit(x): drop the lowest set bit of a register list
    function automatic logic [7:0] clear_lowbit(input logic [7:0] x);
        return x & (x - 8'd1);
    endfunction

endpackage

// File: rtl/lowbit_encoder.sv
// Finds the lowest set bit of an 8-bit register list: its index, whether
// any bit is set, and the list with that bit removed.
module lowbit_encoder (
    input  logic [7:0] din,
    output logic [2:0] idx,
    output logic       valid,
    output logic [7:0] rest
);
    import lca_pkg::*;

    // Priority scan from the top so the lowest set bit wins
    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (din[i]) idx = i[2:0];
        end
        valid = |din;
        rest  = clear_lowbit(din);
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Expands LM/SM instructions held in IF/ID into one micro-instruction per
// set bit of the register list. The original instruction performs the
// lowest-numbered transfer; the rest are injected into IF/ID while the PC
// is frozen.
module lm_sm_sequencer
    import lca_pkg::*;
#(
    parameter logic [3:0] LM_OPCODE = LM_OP_C,
    parameter logic [3:0] SM_OPCODE = SM_OP_C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] if_id_ir,
    input  logic        if_id_valid,
    input  logic        stall_in,
    input  logic        flush_in,
    output logic        ir_load_mux,
    output logic [15:0] new_ir_multi,
    output logic        first_multiple,
    output logic        pc_write,
    output logic        busy
);

    seq_state_t state, state_nxt;
    logic [7:0] rem, rem_nxt;
    logic [6:0] hdr, hdr_nxt;

    logic       is_multi;
    logic       trigger;
    logic [7:0] src;
    logic [6:0] hdr_sel;
    logic [2:0] src_idx;
    logic       src_valid;
    logic [7:0] src_rest;
    logic [15:0] uop;
    logic       ir_unused;

    // IR[8] plays no part in sequencing
    assign ir_unused = if_id_ir[8];

    assign is_multi = (if_id_ir[OPC_MSB:OPC_LSB] == LM_OPCODE) ||
                      (if_id_ir[OPC_MSB:OPC_LSB] == SM_OPCODE);
    assign trigger  = (state == IDLE) && if_id_valid && is_multi &&
                      !stall_in && !flush_in;

    // On trigger the lowest transfer is the instruction already in IF/ID,
    // so generation starts from the list with that bit removed.
    assign src     = trigger ? clear_lowbit(if_id_ir[LIST_MSB:0]) : rem;
    assign hdr_sel = trigger ? if_id_ir[HDR_MSB:HDR_LSB] : hdr;

    lowbit_encoder u_enc (
        .din   (src),
        .idx   (src_idx),
        .valid (src_valid),
        .rest  (src_rest)
    );

    assign uop  = {hdr_sel, src_idx, {UOP_IDX_LSB{1'b0}}};
    assign busy = (state == SEQ);

    // State, remaining list and latched header
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rem   <= 8'h00;
            hdr   <= 7'h00;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            hdr   <= hdr_nxt;
        end
    end

    // Mealy outputs and next-state: flush dominates, stall freezes SEQ
    always_comb begin
        ir_load_mux    = 1'b0;
        pc_write       = 1'b1;
        first_multiple = 1'b0;
        new_ir_multi   = 16'h0000;
        state_nxt      = state;
        rem_nxt        = rem;
        hdr_nxt        = hdr;

        if (flush_in) begin
            state_nxt = IDLE;
            rem_nxt   = 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        first_multiple = 1'b1;
                        if (src_valid) begin
                            ir_load_mux  = 1'b1;
                            pc_write     = 1'b0;
                            new_ir_multi = uop;
                            state_nxt    = SEQ;
                            rem_nxt      = src_rest;
                            hdr_nxt      = if_id_ir[HDR_MSB:HDR_LSB];
                        end
                    end
                end
                SEQ: begin
                    if (stall_in) begin
                        pc_write = 1'b0;
                    end else if (src_valid) begin
                        ir_load_mux  = 1'b1;
                        pc_write     = 1'b0;
                        new_ir_multi = uop;
                        rem_nxt      = src_rest;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: directed scenarios plus random
// traffic, compared against a queue-based transfer model.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] if_id_ir;
    logic        if_id_valid;
    logic        stall_in;
    logic        flush_in;
    logic        ir_load_mux;
    logic [15:0] new_ir_multi;
    logic        first_multiple;
    logic        pc_write;
    logic        busy;

    int checks = 0;
    int errors = 0;

    lm_sm_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .if_id_ir       (if_id_ir),
        .if_id_valid    (if_id_valid),
        .stall_in       (stall_in),
        .flush_in       (flush_in),
        .ir_load_mux    (ir_load_mux),
        .new_ir_multi   (new_ir_multi),
        .first_multiple (first_multiple),
        .pc_write       (pc_write),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a flag for "expanding" and a queue of register
    // numbers still to be transferred, plus the latched header.
    bit         m_active;
    int         m_q[$];
    logic [6:0] m_hdr;
    bit         n_active;
    int         n_q[$];
    logic [6:0] n_hdr;
    logic        e_mux, e_pcw, e_fm, e_busy;
    logic [15:0] e_uop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk_uop(input logic [6:0] h, input int r);
        logic [2:0] r3;
        r3 = r[2:0];
        return {h, r3, 6'b000000};
    endfunction

    task automatic model_eval();
        int bits[$];
        int r;
        e_mux = 1'b0; e_pcw = 1'b1; e_fm = 1'b0; e_uop = 16'h0000;
        e_busy = m_active;
        n_active = m_active; n_q = m_q; n_hdr = m_hdr;
        if (flush_in) begin
            n_active = 1'b0;
            n_q = {};
        end else if (!m_active) begin
            if (if_id_valid && !stall_in &&
                (if_id_ir[15:12] == 4'd6 || if_id_ir[15:12] == 4'd7)) begin
                e_fm = 1'b1;
                for (int i = 0; i < 8; i++)
                    if (if_id_ir[i]) bits.push_back(i);
                if (bits.size() > 1) begin
                    void'(bits.pop_front());
                    r = bits.pop_front();
                    e_uop = mk_uop(if_id_ir[15:9], r);
                    e_mux = 1'b1; e_pcw = 1'b0;
                    n_active = 1'b1; n_q = bits; n_hdr = if_id_ir[15:9];
                end
            end
        end else begin
            if (stall_in) begin
                e_pcw = 1'b0;
            end else if (n_q.size() > 0) begin
                r = n_q.pop_front();
                e_uop = mk_uop(m_hdr, r);
                e_mux = 1'b1; e_pcw = 1'b0;
            end else begin
                n_active = 1'b0;
            end
        end
    endtask

    // Apply inputs mid-cycle, then compare outputs with the model
    task automatic drive(input logic [15:0] ir, input logic v, input logic s,
                         input logic f, input logic r);
        @(negedge clk);
        if_id_ir = ir; if_id_valid = v; stall_in = s; flush_in = f; reset = r;
        #1;
        model_eval();
        chk("ir_load_mux", ir_load_mux, e_mux);
        chk("pc_write", pc_write, e_pcw);
        chk("first_multiple", first_multiple, e_fm);
        chk("new_ir_multi", new_ir_multi, e_uop);
        chk("busy", busy, e_busy);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_active = 1'b0; m_q = {}; m_hdr = 7'h00;
        end else begin
            m_active = n_active; m_q = n_q; m_hdr = n_hdr;
        end
    endtask

    task automatic nop();
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int lowc, busyc;
        logic [15:0] rir;
        int sel;

        reset = 1'b1; if_id_ir = 16'h0; if_id_valid = 1'b0;
        stall_in = 1'b0; flush_in = 1'b0;
        repeat (2) @(posedge clk);
        m_active = 1'b0; m_q = {}; m_hdr = 7'h00;

        // Reset state
        nop();
        chk("rst_busy", busy, 0);
        chk("rst_pcw", pc_write, 1);
        chk("rst_mux", ir_load_mux, 0);
        tick();

        // LM R6, list 8'h06
        drive(16'h6C06, 1, 0, 0, 0);
        chk("t1_uop", new_ir_multi, 16'h6C80);
        chk("t1_fm", first_multiple, 1);
        chk("t1_pcw", pc_write, 0);
        tick();
        nop();
        chk("t1_exit_pcw", pc_write, 1);
        chk("t1_exit_busy", busy, 1);
        tick();
        nop();
        chk("t1_idle", busy, 0);
        tick();

        // SM, list 8'hFF: idx 1..7
        lowc = 0; busyc = 0;
        drive(16'h70FF, 1, 0, 0, 0);
        chk("t2_uop1", new_ir_multi, 16'h7040);
        lowc += (pc_write == 1'b0);
        tick();
        repeat (8) begin
            nop();
            lowc += (pc_write == 1'b0);
            busyc += (busy == 1'b1);
            tick();
        end
        chk("t2_pcw_low", lowc, 7);
        chk("t2_busy_cnt", busyc, 7);

        // Single-register and empty lists
        drive(16'h6010, 1, 0, 0, 0);
        chk("t3_fm10", first_multiple, 1);
        tick();
        nop(); chk("t3_busy10", busy, 0); tick();
        drive(16'h6000, 1, 0, 0, 0);
        chk("t3_fm00", first_multiple, 1);
        chk("t3_mux00", ir_load_mux, 0);
        tick();
        nop(); chk("t3_busy00", busy, 0); tick();

        // SM list 8'h0B with a two-cycle stall in SEQ
        drive(16'h720B, 1, 0, 0, 0); tick();
        drive(16'h0000, 0, 1, 0, 0);
        chk("t4_stall_mux", ir_load_mux, 0);
        chk("t4_stall_pcw", pc_write, 0);
        tick();
        drive(16'h0000, 0, 1, 0, 0); tick();
        nop();
        chk("t4_resume", new_ir_multi, 16'h72C0);
        tick();
        nop(); tick();
        nop(); chk("t4_done", busy, 0); tick();

        // LM list 8'hF0, flush on second SEQ cycle
        drive(16'h64F0, 1, 0, 0, 0); tick();
        nop(); tick();
        drive(16'h0000, 0, 0, 1, 0);
        chk("t5_flush_mux", ir_load_mux, 0);
        chk("t5_flush_pcw", pc_write, 1);
        tick();
        nop(); chk("t5_busy", busy, 0); tick();

        // Reset mid-sequence
        drive(16'h60FF, 1, 0, 0, 0); tick();
        drive(16'h0000, 0, 0, 0, 1); tick();
        nop();
        chk("t6_busy", busy, 0);
        chk("t6_pcw", pc_write, 1);
        chk("t6_mux", ir_load_mux, 0);
        tick();

        // Non-multiple opcode and invalid IF/ID never trigger
        drive(16'h50FF, 1, 0, 0, 0);
        chk("t6_nonmulti_fm", first_multiple, 0);
        tick();
        drive(16'h60FF, 0, 0, 0, 0);
        chk("t6_invalid_fm", first_multiple, 0);
        tick();
        nop(); chk("t6_no_busy", busy, 0); tick();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 3);
            rir = 16'($urandom);
            if (sel < 3) rir[15:12] = (sel == 0) ? 4'd6 : 4'd7;
            drive(rir, ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
